// File: rtl/flaf_trial_sequencer.sv
// Trial sequencer for the FLAF adaptation datapath: resets the filter, streams
// NUM (x,d) samples into it, realigns the filter error by its latency and
// reports completion, underrun or abort.
`timescale 1ns/1ps

module flaf_trial_sequencer #(
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned LAT     = 6,
    parameter int unsigned RST_CYC = 2,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] num_samples,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WIDTH-1:0] s_x,
    input  logic [WIDTH-1:0] s_d,
    output logic             flt_reset,
    output logic [WIDTH-1:0] flt_signal_in,
    output logic [WIDTH-1:0] flt_desired_in,
    input  logic [WIDTH-1:0] flt_error,
    output logic             err_valid,
    output logic [WIDTH-1:0] err_data,
    output logic             busy,
    output logic             done,
    output logic             underrun
);

    localparam int unsigned RST_W = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RST,
        S_RUN,
        S_FLUSH,
        S_DONE
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   num;
    logic [CNT_W-1:0]   acc_cnt;
    logic [CNT_W-1:0]   err_cnt;
    logic [RST_W-1:0]   rst_cnt;
    // vpipe[k] set: the filter input driven k cycles ago was a real sample
    logic [LAT:0]       vpipe;
    logic               hs;

    // Sample handshake; s_ready is only ever high while in RUN
    assign hs = (state == S_RUN) && s_ready && s_valid;

    // Trial FSM, filter input registers, error alignment pipe and counters
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= S_IDLE;
            flt_reset      <= 1'b1;
            s_ready        <= 1'b0;
            flt_signal_in  <= '0;
            flt_desired_in <= '0;
            err_valid      <= 1'b0;
            err_data       <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            underrun       <= 1'b0;
            num            <= '0;
            acc_cnt        <= '0;
            err_cnt        <= '0;
            rst_cnt        <= '0;
            vpipe          <= '0;
        end else begin
            done           <= 1'b0;
            flt_signal_in  <= hs ? s_x : '0;
            flt_desired_in <= hs ? s_d : '0;
            vpipe          <= {vpipe[LAT-1:0], hs};
            err_valid      <= vpipe[LAT];
            if (vpipe[LAT]) begin
                err_data <= flt_error;
            end
            if (err_valid) begin
                err_cnt <= err_cnt + CNT_W'(1);
            end

            case (state)
                S_IDLE: begin
                    flt_reset <= 1'b1;
                    s_ready   <= 1'b0;
                    if (start && !abort) begin
                        num      <= num_samples;
                        underrun <= 1'b0;
                        acc_cnt  <= '0;
                        err_cnt  <= '0;
                        rst_cnt  <= '0;
                        busy     <= 1'b1;
                        state    <= S_RST;
                    end
                end
                S_RST: begin
                    if (rst_cnt == RST_W'(RST_CYC - 1)) begin
                        if (num == '0) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else begin
                            state     <= S_RUN;
                            flt_reset <= 1'b0;
                            s_ready   <= 1'b1;
                        end
                    end else begin
                        rst_cnt <= rst_cnt + RST_W'(1);
                    end
                end
                S_RUN: begin
                    if (hs) begin
                        acc_cnt <= acc_cnt + CNT_W'(1);
                        if (acc_cnt + CNT_W'(1) == num) begin
                            state   <= S_FLUSH;
                            s_ready <= 1'b0;
                        end
                    end else if (s_ready) begin
                        // Filter cannot stall: a gap kills the trial
                        underrun  <= 1'b1;
                        state     <= S_IDLE;
                        s_ready   <= 1'b0;
                        busy      <= 1'b0;
                        flt_reset <= 1'b1;
                        vpipe     <= '0;
                        err_valid <= 1'b0;
                    end
                end
                S_FLUSH: begin
                    if (err_valid && (err_cnt + CNT_W'(1) == num)) begin
                        state     <= S_DONE;
                        done      <= 1'b1;
                        flt_reset <= 1'b1;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase

            // Abort overrides everything above outside IDLE
            if (abort && (state != S_IDLE)) begin
                state          <= S_IDLE;
                s_ready        <= 1'b0;
                busy           <= 1'b0;
                done           <= 1'b0;
                flt_reset      <= 1'b1;
                flt_signal_in  <= '0;
                flt_desired_in <= '0;
                vpipe          <= '0;
                err_valid      <= 1'b0;
            end
        end
    end

endmodule
